regfile_write_arbiter: RTL

- Owns the single write port of nbit_register_file.
- After reset it runs a zero-fill sweep over every register, since the register file has no reset of its own.
- After the sweep it shares the write port between two writeback requesters: A (ALU result) and B (load/memory result), using valid/ready handshakes and round-robin priority.
- Outputs are registered and drive the register file's write_data, write_address and RegWrite directly.

---
 rtl/regfile_ctl_pkg.sv | 12 +
 rtl/regfile_write_arbiter_rr_arb2.sv | 22 ++
 rtl/regfile_write_arbiter.sv | 91 +++++++++
 3 files changed

// File: rtl/regfile_ctl_pkg.sv
// Shared encodings for the register-file write-port controller.
package regfile_ctl_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/regfile_write_arbiter_rr_arb2.sv
// Two-way round-robin grant: pri only matters, and only advances, under contention.
module rr_arb2
    import regfile_ctl_pkg::*;
(
    input  logic [1:0] req,
    input  logic       pri,
    output logic [1:0] gnt,
    output logic       next_pri
);

    always_comb begin
        gnt      = 2'b00;
        next_pri = pri;
        if (req == 2'b11) begin
            gnt      = (pri == REQ_A) ? 2'b01 : 2'b10;
            next_pri = (pri == REQ_A) ? REQ_B : REQ_A;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owns the register file write port: zero-fill sweep after reset, then
// round-robin arbitration between the ALU (A) and load (B) writeback paths.
module regfile_write_arbiter
    import regfile_ctl_pkg::*;
#(
    parameter int unsigned data_width   = 32,
    parameter int unsigned select_width = 5,
    parameter bit          zero_r0      = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    a_valid,
    input  logic [select_width-1:0] a_addr,
    input  logic [data_width-1:0]   a_data,
    output logic                    a_ready,
    input  logic                    b_valid,
    input  logic [select_width-1:0] b_addr,
    input  logic [data_width-1:0]   b_data,
    output logic                    b_ready,
    output logic [data_width-1:0]   write_data,
    output logic [select_width-1:0] write_address,
    output logic                    RegWrite,
    output logic                    init_done
);

    localparam int unsigned N = 2 ** select_width;

    state_t                  state;
    logic [select_width-1:0] cnt;
    logic                    pri;
    logic                    run;
    logic [1:0]              req;
    logic [1:0]              gnt;
    logic                    next_pri;

    assign run     = (state == ST_RUN);
    assign a_ready = run & (~b_valid | (pri == REQ_A));
    assign b_ready = run & (~a_valid | (pri == REQ_B));
    assign req     = {b_valid & run, a_valid & run};

    rr_arb2 u_arb (
        .req      (req),
        .pri      (pri),
        .gnt      (gnt),
        .next_pri (next_pri)
    );

    // Sweep counter, priority and write-port registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_INIT;
            cnt           <= '0;
            pri           <= REQ_A;
            RegWrite      <= 1'b0;
            write_address <= '0;
            write_data    <= '0;
            init_done     <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    RegWrite      <= 1'b1;
                    write_address <= cnt;
                    write_data    <= '0;
                    cnt           <= cnt + select_width'(1);
                    if (cnt == select_width'(N - 1)) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    pri <= next_pri;
                    if (gnt[0]) begin
                        write_address <= a_addr;
                        write_data    <= a_data;
                        RegWrite      <= !(zero_r0 && (a_addr == '0));
                    end else if (gnt[1]) begin
                        write_address <= b_addr;
                        write_data    <= b_data;
                        RegWrite      <= !(zero_r0 && (b_addr == '0));
                    end else begin
                        RegWrite <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

endmodule
